// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator. Every output is registered from the
// next-state counter values, so DrawX/DrawY and all strobes describe the same
// pixel in the same cycle. Reset parks the counters on the last pixel of a
// frame, which makes the first edge after release land cleanly on (0,0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit compare constants; counters never exceed 1023.
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Refuse to elaborate geometries that do not fit the 10-bit counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    // Next pixel position and the strobes that belong to that pixel.
    always_comb begin
        x_d = (x_q == H_MAX) ? 10'd0 : x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_MAX) begin
            y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
        end
        blank_d = (x_d < H_ACT) && (y_d < V_ACT);
        hs_d    = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_d    = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_ON : SYNC_OFF;
        ls_d    = (x_d == 10'd0);
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
        fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
    end

    // State registers; reset lands on the last pixel of a frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q     <= H_MAX;
            y_q     <= V_MAX;
            blank_q <= 1'b0;
            hs_q    <= SYNC_OFF;
            vs_q    <= SYNC_OFF;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing generator for the 640x480@60 Hz display path. It runs on the 25 MHz pixel clock and produces the DrawX/DrawY coordinates, the active-video flag `blank`, and the hs/vs sync strobes. Sprite/ROM stages consume these: they read the ROM on the falling edge and register the pixel on the rising edge. Frame and line markers are also produced for animation and per-line logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hs/vs (0 = active-low)

Ports:
vga_clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current horizontal count, 0..H_TOTAL-1
DrawY  output  10  current vertical count, 0..V_TOTAL-1
blank  output  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE); 0 = blanked
hs  output  1  horizontal sync, level SYNC_POL when asserted
vs  output  1  vertical sync, level SYNC_POL when asserted
line_start  output  1  one-cycle pulse when DrawX==0
frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
frame_count  output  8  frames started since reset, wraps

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- One clock domain (vga_clk). Reset is asynchronous and active-high. All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values:
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524).
  - blank=0, hs=vs=~SYNC_POL (deasserted), line_start=0, frame_start=0, frame_count=0.
  - The reset state is therefore the last pixel of a frame, and it is self-consistent.
- Horizontal counter:
  - Each rising edge: if DrawX==H_TOTAL-1 then DrawX<=0, else DrawX<=DrawX+1.
- Vertical counter:
  - DrawY changes only on edges where DrawX wraps.
  - If DrawY==V_TOTAL-1 then DrawY<=0, else DrawY<=DrawY+1.
- Every other output is computed from the next-state counter values and registered on the same edge. All outputs therefore describe the same (DrawX, DrawY) pixel in the same cycle, with zero relative skew.
  - blank <= (nextX < H_ACTIVE) && (nextY < V_ACTIVE).
  - hs asserted iff H_ACTIVE+H_FP <= nextX < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 inclusive.
  - vs asserted iff V_ACTIVE+V_FP <= nextY < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the full 800-pixel duration of each of those lines.
  - line_start <= (nextX==0).
  - frame_start <= (nextX==0 && nextY==0).
  - frame_count increments (mod 256) on the same edge that sets frame_start.
- First edge after reset release:
  - DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
  - The first frame is complete; no partial frame is produced.
- Reset asserted mid-frame: all outputs immediately (asynchronously) take their reset values. Counting restarts as described above on release.
- Per-frame counts:
  - Exactly H_TOTAL*V_TOTAL = 420000 cycles between consecutive frame_start pulses.
  - blank high for H_ACTIVE*V_ACTIVE = 307200 cycles per frame.
  - hs asserted 96 cycles per line; vs asserted 1600 cycles per frame.
- Counters use widths of 10 bits, and the compare constants are derived from the parameters.
- Parameter sets with H_TOTAL>1024 or V_TOTAL>1024 are illegal.

Test Plan:
- Reset held, then released → before the first edge: DrawX=799, DrawY=524, blank=0, hs=vs=1. After edge 1: DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1. After edge 2: frame_start=0, DrawX=1.
- Line 0 scan → blank=1 for DrawX 0..639 and 0 at 640. hs=0 exactly for DrawX 656..751 (96 cycles). line_start is high only at DrawX=0. The wrap 799→0 increments DrawY to 1.
- Full frame → frame_start pulses are 420000 cycles apart; blank-high count is 307200; vs=0 only for DrawY 490..491 (1600 cycles); DrawY wraps 524→0 at DrawX 799→0.
- Reset pulsed at DrawX=300, DrawY=200 → outputs return to reset values without waiting for a clock edge. After release, the next edge gives (0,0) with frame_start=1 and frame_count=1.
- Run 256 frames → frame_count goes 255→0 on the 256th frame_start. No other output is disturbed.
- SYNC_POL=1 variant → hs/vs idle at 0 and assert to 1 over the same windows (656..751, lines 490..491).
